// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants and FSM encoding for the iomem tone generator
//
// Purpose: register indices, STAT/CTRL bit positions and playback state type
//          used by iomem_tone_gen and its command FIFO.
// Ports:   none (package).
package tone_pkg;

  localparam logic [1:0] REG_CMD  = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_TDIV = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_LVL_LSB = 4;

  localparam int CTRL_ABORT   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_CLR_OVF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } tone_state_t;

endpackage

// File: rtl/tone_cmd_fifo.sv
// rtl/tone_cmd_fifo.sv - synchronous 32-bit command FIFO with flush
//
// Purpose: holds queued {duration, half_period} tone commands.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   push, push_data   write request and data (ignored when full)
//   pop               read request, head advances (ignored when empty)
//   flush             empties the FIFO, overrides push/pop
//   head              current oldest entry
//   full, empty       status flags
//   level             number of stored entries
module tone_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [31:0]   head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + LW'(1);
      else if (do_pop && !do_push) count <= count - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/iomem_tone_gen.sv
// rtl/iomem_tone_gen.sv - PicoSoC iomem tone/buzzer peripheral with command queue
//
// Purpose: bus decode, register file and playback FSM; queued notes are played
//          back to back as a square wave, irq_done pulses per finished note.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   iomem_valid/ready  bus request / one-cycle acknowledge
//   iomem_wstrb        byte strobes, 0 = read
//   iomem_addr         [31:24] page, [3:2] register
//   iomem_wdata/rdata  write data / read data (valid with ready)
//   tone_out           square-wave output
//   tone_busy          high while a note plays
//   irq_done           one-cycle pulse at natural note end when IRQ_EN=1
module iomem_tone_gen
  import tone_pkg::*;
#(
  parameter logic [7:0] ADDR_PAGE    = 8'h06,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         TICK_DIV_RST = 12000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        tone_out,
  output logic        tone_busy,
  output logic        irq_done
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic          hit, wr, cmd_wr, ctrl_wr, tdiv_wr, abort;
  logic [1:0]    reg_sel;
  logic [31:0]   rd_val;
  logic          irq_en, ovf;
  logic [23:0]   tick_div;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [LW-1:0] fifo_level;
  tone_state_t   state;
  logic [15:0]   hp, half_cnt, dur_cnt;
  logic [23:0]   tick_cnt;
  logic          unused_addr;

  assign unused_addr = ^{iomem_addr[23:4], iomem_addr[1:0]};

  // The !iomem_ready term keeps a held request from being decoded twice.
  assign hit     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_PAGE);
  assign reg_sel = iomem_addr[3:2];
  assign wr      = hit && (iomem_wstrb != 4'h0);
  assign cmd_wr  = wr && (reg_sel == REG_CMD)  && (iomem_wstrb == 4'hF);
  assign ctrl_wr = wr && (reg_sel == REG_CTRL) && iomem_wstrb[0];
  assign tdiv_wr = wr && (reg_sel == REG_TDIV) && (iomem_wstrb == 4'hF);
  assign abort   = ctrl_wr && iomem_wdata[CTRL_ABORT];

  assign fifo_pop  = (state == IDLE) && !fifo_empty && !abort;
  assign tone_busy = (state == PLAY);

  tone_cmd_fifo #(.DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (cmd_wr),
    .push_data (iomem_wdata),
    .pop       (fifo_pop),
    .flush     (abort),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STAT: begin
        rd_val[STAT_BUSY]                    = tone_busy;
        rd_val[STAT_EMPTY]                   = fifo_empty;
        rd_val[STAT_FULL]                    = fifo_full;
        rd_val[STAT_OVF]                     = ovf;
        rd_val[STAT_LVL_LSB+3:STAT_LVL_LSB]  = 4'(fifo_level);
      end
      REG_CTRL: rd_val[CTRL_IRQ_EN] = irq_en;
      REG_TDIV: rd_val[23:0]        = tick_div;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      irq_en      <= 1'b0;
      ovf         <= 1'b0;
      tick_div    <= 24'(TICK_DIV_RST);
    end else begin
      iomem_ready <= hit;
      iomem_rdata <= (hit && (iomem_wstrb == 4'h0)) ? rd_val : '0;
      if (ctrl_wr) begin
        irq_en <= iomem_wdata[CTRL_IRQ_EN];
        if (iomem_wdata[CTRL_CLR_OVF]) ovf <= 1'b0;
      end
      // Full is the pre-pop level, so a write racing a pop is still dropped.
      if (cmd_wr && fifo_full) ovf <= 1'b1;
      if (tdiv_wr) tick_div <= (iomem_wdata[23:0] == 24'd0) ? 24'd1 : iomem_wdata[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tone_out <= 1'b0;
      irq_done <= 1'b0;
      hp       <= '0;
      half_cnt <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      irq_done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        tone_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tone_out <= 1'b0;
            // The head is captured as it is popped; LOAD then works on the copy.
            if (!fifo_empty) begin
              hp      <= fifo_head[15:0];
              dur_cnt <= fifo_head[31:16];
              state   <= LOAD;
            end
          end
          LOAD: begin
            if (dur_cnt == 16'd0) begin
              state <= IDLE;
            end else begin
              half_cnt <= hp - 16'd1;
              tick_cnt <= tick_div - 24'd1;
              tone_out <= 1'b0;
              state    <= PLAY;
            end
          end
          PLAY: begin
            if (half_cnt == 16'd0) begin
              half_cnt <= hp - 16'd1;
              if (hp != 16'd0) tone_out <= ~tone_out;
            end else begin
              half_cnt <= half_cnt - 16'd1;
            end
            if (tick_cnt == 16'd0) begin
              tick_cnt <= tick_div - 24'd1;
              dur_cnt  <= dur_cnt - 16'd1;
              if (dur_cnt == 16'd1) begin
                tone_out <= 1'b0;
                irq_done <= irq_en;
                state    <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt - 24'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iomem_tone_gen.sv
// tb/tb_iomem_tone_gen.sv - self-checking bench for iomem_tone_gen
module tb_iomem_tone_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  wire         iomem_ready;
  wire  [31:0] iomem_rdata;
  wire         tone_out, tone_busy, irq_done;

  always #5 clk = ~clk;

  iomem_tone_gen dut (
    .clk         (clk),
    .resetn      (resetn),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .tone_out    (tone_out),
    .tone_busy   (tone_busy),
    .irq_done    (irq_done)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of commands, a note that starts two cycles after
  // it leaves the queue and lasts dur*TICK_DIV cycles, square wave from elapsed time.
  logic [31:0] mq[$];
  bit          m_ready, m_irq, m_ovf, m_irq_en, m_playing, m_loading;
  logic [31:0] m_rdata;
  logic [23:0] m_tdiv;
  logic [15:0] m_hp, m_dur;
  int          m_elapsed, m_len;

  always @(posedge clk) begin : model
    bit          hit, wr, abort;
    logic [1:0]  rs;
    logic [31:0] rv, nxt;
    int          sz;
    if (!resetn) begin
      mq.delete();
      m_ready = 0; m_irq = 0; m_ovf = 0; m_irq_en = 0; m_playing = 0; m_loading = 0;
      m_rdata = '0; m_tdiv = 24'd12000; m_hp = '0; m_dur = '0; m_elapsed = 0; m_len = 0;
    end else begin
      hit = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h06);
      wr  = hit && (iomem_wstrb != 4'h0);
      rs  = iomem_addr[3:2];
      sz  = mq.size();
      case (rs)
        2'd1:    rv = {24'd0, 4'(sz), m_ovf, (sz == DEPTH), (sz == 0), m_playing};
        2'd2:    rv = {30'd0, m_irq_en, 1'b0};
        2'd3:    rv = {8'd0, m_tdiv};
        default: rv = '0;
      endcase
      abort = wr && (rs == 2'd2) && iomem_wstrb[0] && iomem_wdata[0];
      m_irq = 0;
      if (abort) begin
        mq.delete();
        m_playing = 0;
        m_loading = 0;
      end else begin
        if (m_playing) begin
          m_elapsed++;
          if (m_elapsed == m_len) begin
            m_playing = 0;
            m_irq = m_irq_en;
          end
        end else if (m_loading) begin
          m_loading = 0;
          if (m_dur != 16'd0) begin
            m_playing = 1;
            m_elapsed = 0;
            m_len = int'(m_dur) * int'(m_tdiv);
          end
        end else if (sz > 0) begin
          nxt = mq.pop_front();
          m_hp = nxt[15:0];
          m_dur = nxt[31:16];
          m_loading = 1;
        end
        if (wr && (rs == 2'd0) && (iomem_wstrb == 4'hF)) begin
          if (sz == DEPTH) m_ovf = 1;
          else mq.push_back(iomem_wdata);
        end
      end
      if (wr && (rs == 2'd2) && iomem_wstrb[0]) begin
        m_irq_en = iomem_wdata[1];
        if (iomem_wdata[2]) m_ovf = 0;
      end
      if (wr && (rs == 2'd3) && (iomem_wstrb == 4'hF))
        m_tdiv = (iomem_wdata[23:0] == 24'd0) ? 24'd1 : iomem_wdata[23:0];
      m_rdata = (hit && (iomem_wstrb == 4'h0)) ? rv : '0;
      m_ready = hit;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit exp_tone;
    if (chk_en) begin
      exp_tone = m_playing && (m_hp != 16'd0) && (((m_elapsed / int'(m_hp)) % 2) == 1);
      check("ready", {31'd0, iomem_ready}, {31'd0, m_ready});
      check("rdata", iomem_rdata, m_rdata);
      check("tone_out", {31'd0, tone_out}, {31'd0, exp_tone});
      check("tone_busy", {31'd0, tone_busy}, {31'd0, m_playing});
      check("irq_done", {31'd0, irq_done}, {31'd0, m_irq});
    end
  end

  // Running totals for the hand-computed expectations.
  int cyc = 0, tot_irq = 0, tot_busy = 0, tot_rise = 0;
  int irq_cyc[$];
  logic prev_tone = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (irq_done === 1'b1) begin tot_irq++; irq_cyc.push_back(cyc); end
    if (tone_busy === 1'b1) tot_busy++;
    if (tone_out === 1'b1 && prev_tone === 1'b0) tot_rise++;
    prev_tone = tone_out;
  end

  task automatic bus(input logic [7:0] page, input logic [1:0] rs, input logic [3:0] ws,
                     input logic [31:0] wd, output logic [31:0] rd, output bit acked, output int lat);
    iomem_addr  = {page, 20'd0, rs, 2'b00};
    iomem_wstrb = ws;
    iomem_wdata = wd;
    iomem_valid = 1'b1;
    acked = 0; rd = '0; lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin acked = 1; rd = iomem_rdata; lat = i; break; end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic wr_reg(input logic [1:0] rs, input logic [31:0] wd);
    logic [31:0] rd; bit ak; int lat;
    bus(8'h06, rs, 4'hF, wd, rd, ak, lat);
    check("write_ack", {31'd0, ak}, 32'd1);
  endtask

  task automatic rd_reg(input string name, input logic [1:0] rs, input logic [31:0] exp);
    logic [31:0] rd; bit ak; int lat;
    bus(8'h06, rs, 4'h0, '0, rd, ak, lat);
    check({name, "_ack"}, {31'd0, ak}, 32'd1);
    check(name, rd, exp);
  endtask

  function automatic logic [31:0] cmd(input int dur, input int hp);
    return {16'(dur), 16'(hp)};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] rd;
    bit ak;
    int lat, b0, i0, r0, n;
    bit seen;

    // 1: reset, STAT read latency, page miss, TDIV reset value and zero clamp
    @(posedge clk); #1;
    chk_en = 1'b1;
    cycles(2);
    check("reset_outputs", {iomem_ready, tone_out, tone_busy, irq_done, iomem_rdata}, 36'd0);
    resetn = 1'b1;
    cycles(1);
    bus(8'h06, 2'd1, 4'h0, '0, rd, ak, lat);
    check("t1_stat", rd, 32'h0000_0002);
    check("t1_ack_latency", lat, 0);
    bus(8'h05, 2'd1, 4'h0, '0, rd, ak, lat);
    check("t1_miss_no_ack", {31'd0, ak}, 32'd0);
    rd_reg("t1_tdiv_rst", 2'd3, 32'd12000);
    wr_reg(2'd3, 32'd0);
    rd_reg("t1_tdiv_zero", 2'd3, 32'd1);

    // 2: TDIV=10, one note dur=3 hp=5, IRQ disabled
    wr_reg(2'd3, 32'd10);
    b0 = tot_busy; i0 = tot_irq; r0 = tot_rise;
    wr_reg(2'd0, cmd(3, 5));
    cycles(45);
    check("t2_play_cycles", tot_busy - b0, 30);
    check("t2_rises", tot_rise - r0, 3);
    check("t2_no_irq", tot_irq - i0, 0);

    // 3: IRQ on, long note then 5 short ones: one dropped, OVF, four 10-cycle spaced irqs
    wr_reg(2'd2, 32'h2);
    wr_reg(2'd3, 32'd4);
    i0 = tot_irq;
    irq_cyc.delete();
    wr_reg(2'd0, cmd(20, 3));
    for (int k = 0; k < 5; k++) wr_reg(2'd0, cmd(2, 1));
    rd_reg("t3_stat_full_ovf", 2'd1, 32'h0000_004D);
    wr_reg(2'd2, 32'h6);
    rd_reg("t3_stat_ovf_clr", 2'd1, 32'h0000_0045);
    rd_reg("t3_ctrl", 2'd2, 32'h0000_0002);
    cycles(160);
    check("t3_irq_count", tot_irq - i0, 5);
    n = irq_cyc.size();
    for (int k = 1; k < n; k++) check("t3_irq_spacing", irq_cyc[k] - irq_cyc[k-1], 10);

    // 4: dur=0 note skipped, dur=1 rest plays silently for one tick
    b0 = tot_busy; i0 = tot_irq; r0 = tot_rise;
    wr_reg(2'd0, cmd(0, 7));
    wr_reg(2'd0, cmd(1, 0));
    cycles(20);
    check("t4_irq_count", tot_irq - i0, 1);
    check("t4_play_cycles", tot_busy - b0, 4);
    check("t4_rises", tot_rise - r0, 0);

    // 5: mid-note abort with two queued
    wr_reg(2'd0, cmd(20, 3));
    wr_reg(2'd0, cmd(2, 1));
    wr_reg(2'd0, cmd(2, 1));
    cycles(10);
    bus(8'h06, 2'd2, 4'h1, 32'h3, rd, ak, lat);
    check("t5_abort_ack", {31'd0, ak}, 32'd1);
    check("t5_abort_outputs", {30'd0, tone_out, tone_busy}, 32'd0);
    rd_reg("t5_stat_empty", 2'd1, 32'h0000_0002);
    b0 = tot_busy; i0 = tot_irq;
    cycles(100);
    check("t5_no_play", tot_busy - b0, 0);
    check("t5_no_irq", tot_irq - i0, 0);

    // 6: CMD write landing on the pop edge leaves the level unchanged
    wr_reg(2'd0, cmd(3, 2));
    wr_reg(2'd0, cmd(1, 1));
    wr_reg(2'd0, cmd(1, 1));
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tone_busy === 1'b0) begin seen = 1; break; end
    end
    check("t6_note_end_seen", {31'd0, seen}, 32'd1);
    wr_reg(2'd0, cmd(1, 1));
    rd_reg("t6_stat_level", 2'd1, 32'h0000_0021);
    cycles(60);
    rd_reg("t6_stat_drained", 2'd1, 32'h0000_0002);

    // 7: reset mid-note
    wr_reg(2'd0, cmd(5, 3));
    cycles(8);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("t7_reset_outputs", {iomem_ready, tone_out, tone_busy, irq_done, iomem_rdata}, 36'd0);
    cycles(2);
    resetn = 1'b1;
    cycles(1);
    rd_reg("t7_tdiv_rst", 2'd3, 32'd12000);
    rd_reg("t7_stat", 2'd1, 32'h0000_0002);
    rd_reg("t7_ctrl", 2'd2, 32'h0000_0000);
    cycles(3);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
